// File: rtl/ps_fetch_queue.sv
// Instruction prefetch queue: issues sequential PM reads, buffers tagged words, serves the PS.
// Latency: issue-to-valid 2 cycles (1 with FQ_BYPASS_EN defined); jump-to-valid 3 (2 with bypass).
// Backpressure: issue is credit-limited by occupancy plus in-flight read; ps_fq_rdy low holds the head.
module ps_fetch_queue #(
  parameter int                 PMA_SIZE = 16,
  parameter int                 PMD_SIZE = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [PMA_SIZE-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       fq_pm_cslt,
  output logic [PMA_SIZE-1:0]        fq_pm_add,
  input  logic [PMD_SIZE-1:0]        pm_fq_op,
  input  logic                       ps_pm_busy,
  input  logic                       ps_fq_rdy,
  output logic                       fq_ps_vld,
  output logic [PMD_SIZE-1:0]        fq_ps_instr,
  output logic [PMA_SIZE-1:0]        fq_ps_pc,
  input  logic                       ps_fq_jmp,
  input  logic [PMA_SIZE-1:0]        ps_fq_jadd,
  output logic [$clog2(DEPTH+1)-1:0] fq_ps_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_REDIR} state_t;

  state_t              state;
  logic [PMA_SIZE-1:0] fpc;
  logic [PMA_SIZE-1:0] inflight_tag;
  logic                inflight;
  logic [CW-1:0]       count;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PMD_SIZE-1:0] mem_instr [DEPTH];
  logic [PMA_SIZE-1:0] mem_pc    [DEPTH];

  logic [CW:0] occ;
  logic        issue;
  logic        resp;
  logic        empty;
  logic        fifo_wr;
  logic        fifo_rd;
  logic        byp;

  // Credit check counts the outstanding read; a pop this cycle is deliberately not credited.
  always_comb begin
    occ   = {1'b0, count} + {{CW{1'b0}}, inflight};
    issue = (state != ST_BOOT) && !ps_pm_busy && !ps_fq_jmp && (occ < (CW+1)'(DEPTH));
    // A response in the post-jump cycle, or one landing in the jump cycle itself, is stale.
    resp  = inflight && (state != ST_REDIR) && !ps_fq_jmp;
    empty = (count == '0);
  end

  assign fq_pm_cslt = issue;
  assign fq_pm_add  = fpc;
  assign fq_ps_cnt  = count;

  // Head presentation and FIFO write/read enables, with optional empty-queue bypass.
  always_comb begin
    byp         = 1'b0;
    fq_ps_vld   = !empty;
    fq_ps_instr = '0;
    fq_ps_pc    = '0;
    fifo_wr     = resp;
    fifo_rd     = ps_fq_rdy && !empty;
`ifdef FQ_BYPASS_EN
    byp         = resp && empty;
    fq_ps_vld   = !empty || byp;
    fifo_wr     = resp && !(byp && ps_fq_rdy);
`endif
    if (!empty) begin
      fq_ps_instr = mem_instr[rd_ptr];
      fq_ps_pc    = mem_pc[rd_ptr];
    end else if (byp) begin
      fq_ps_instr = pm_fq_op;
      fq_ps_pc    = inflight_tag;
    end
  end

  // Fetch FSM: boot delay, sequential PC advance, redirect on jump, in-flight tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_BOOT;
      fpc          <= RESET_PC;
      inflight     <= 1'b0;
      inflight_tag <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_tag <= fpc;
        fpc          <= fpc + PMA_SIZE'(1);
      end
      if (ps_fq_jmp) begin
        state <= ST_REDIR;
        fpc   <= ps_fq_jadd;
      end else begin
        state <= ST_RUN;
      end
    end
  end

  // Queue pointers and occupancy; a jump empties the queue outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (ps_fq_jmp) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PW'(1);
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (fifo_wr && !ps_fq_jmp) begin
      mem_instr[wr_ptr] <= pm_fq_op;
      mem_pc[wr_ptr]    <= inflight_tag;
    end
  end

endmodule

// File: tb/tb_ps_fetch_queue.sv
// Randomized bench for ps_fetch_queue against a queue-based reference model.
// Model: list of buffered fetch addresses, one pending read, next fetch PC.
// Directed phases follow the fill / stream / jump / busy / wrap / reset scenarios.
module tb_ps_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fq_pm_cslt;
  logic [15:0] fq_pm_add;
  logic [31:0] pm_fq_op = 32'hDEAD_BEEF;
  logic        ps_pm_busy = 1'b0;
  logic        ps_fq_rdy = 1'b0;
  logic        fq_ps_vld;
  logic [31:0] fq_ps_instr;
  logic [15:0] fq_ps_pc;
  logic        ps_fq_jmp = 1'b0;
  logic [15:0] ps_fq_jadd = 16'h0;
  logic [2:0]  fq_ps_cnt;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [15:0] m_q[$];
  int          m_pend;
  logic [15:0] m_tag;
  logic [15:0] m_pc;
  bit          m_boot;
  bit          m_redir;

  // last observed DUT outputs
  logic        obs_vld, obs_cslt, obs_pop;
  logic [15:0] obs_add, obs_pc;
  logic [2:0]  obs_cnt;

  ps_fetch_queue dut (
    .clk(clk), .reset(reset),
    .fq_pm_cslt(fq_pm_cslt), .fq_pm_add(fq_pm_add), .pm_fq_op(pm_fq_op),
    .ps_pm_busy(ps_pm_busy), .ps_fq_rdy(ps_fq_rdy),
    .fq_ps_vld(fq_ps_vld), .fq_ps_instr(fq_ps_instr), .fq_ps_pc(fq_ps_pc),
    .ps_fq_jmp(ps_fq_jmp), .ps_fq_jadd(ps_fq_jadd), .fq_ps_cnt(fq_ps_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pm_word(input logic [15:0] a);
    return 32'hA000_0000 + {16'h0, a};
  endfunction

  // program memory: one-cycle read latency, garbage when not selected
  always @(posedge clk) pm_fq_op <= fq_pm_cslt ? pm_word(fq_pm_add) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend  = 0;
    m_tag   = 16'h0;
    m_pc    = 16'h0000;
    m_boot  = 1'b1;
    m_redir = 1'b0;
  endtask

  // One clock: drive inputs just after negedge, compare, advance model at posedge.
  task automatic cycle(input logic busy, input logic rdy, input logic jmp, input logic [15:0] jadd);
    logic        resp, byp, e_cslt, e_vld;
    logic [15:0] e_pc;
    logic [31:0] e_instr;
    ps_pm_busy = busy;
    ps_fq_rdy  = rdy;
    ps_fq_jmp  = jmp;
    ps_fq_jadd = jadd;
    #1;
    resp   = (m_pend != 0) && !m_redir && !jmp;
    e_cslt = !m_boot && !busy && !jmp && ((m_q.size() + m_pend) < DEPTH);
    byp    = 1'b0;
`ifdef FQ_BYPASS_EN
    byp    = resp && (m_q.size() == 0);
`endif
    e_vld   = (m_q.size() != 0) || byp;
    e_pc    = (m_q.size() != 0) ? m_q[0] : (byp ? m_tag : 16'h0);
    e_instr = e_vld ? pm_word(e_pc) : 32'h0;
    check("cslt", {31'b0, fq_pm_cslt}, {31'b0, e_cslt});
    if (e_cslt) check("pm_add", {16'h0, fq_pm_add}, {16'h0, m_pc});
    check("vld", {31'b0, fq_ps_vld}, {31'b0, e_vld});
    check("cnt", {29'b0, fq_ps_cnt}, m_q.size());
    check("pc", {16'h0, fq_ps_pc}, {16'h0, e_pc});
    check("instr", fq_ps_instr, e_instr);
    obs_vld  = fq_ps_vld;
    obs_cslt = fq_pm_cslt;
    obs_add  = fq_pm_add;
    obs_pc   = fq_ps_pc;
    obs_cnt  = fq_ps_cnt;
    obs_pop  = fq_ps_vld && rdy;
    @(posedge clk);
    if (jmp) begin
      m_q.delete();
      m_pend = 0;
      m_pc   = jadd;
    end else begin
      if (rdy && m_q.size() != 0) void'(m_q.pop_front());
      else if (rdy && byp) resp = 1'b0;
      if (resp) m_q.push_back(m_tag);
      if (e_cslt) begin
        m_tag  = m_pc;
        m_pc   = m_pc + 16'h1;
        m_pend = 1;
      end else begin
        m_pend = 0;
      end
    end
    m_redir = jmp;
    m_boot  = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cslt"}, {31'b0, fq_pm_cslt}, 32'h0);
    check({tag, "_vld"}, {31'b0, fq_ps_vld}, 32'h0);
    check({tag, "_instr"}, fq_ps_instr, 32'h0);
    check({tag, "_pc"}, {16'h0, fq_ps_pc}, 32'h0);
    check({tag, "_cnt"}, {29'b0, fq_ps_cnt}, 32'h0);
  endtask

  initial begin
    int          n;
    int          k;
    int          max_cnt;
    bit          found;
    logic [15:0] last_pc;
    bit          have_last;
    logic [15:0] got_pcs[$];

    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;

    // fill from reset with no consumer
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0);
      if (obs_cslt) n++;
    end
    check("fill_fetches", n, 4);
    check("fill_cnt", {29'b0, obs_cnt}, 4);
    check("fill_head_pc", {16'h0, obs_pc}, 32'h0);
    check("fill_head_instr", fq_ps_instr, 32'hA000_0000);

    // continuous streaming
    max_cnt = 0;
    have_last = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0);
      if (i >= 6 && obs_cnt > max_cnt) max_cnt = obs_cnt;
      if (obs_pop) begin
        if (have_last) check("stream_seq", {16'h0, obs_pc}, {16'h0, last_pc + 16'h1});
        last_pc = obs_pc;
        have_last = 1'b1;
      end
    end
    check("stream_max_cnt_le2", {31'b0, max_cnt <= 2}, 32'h1);

    // build 3 entries + 1 in flight, then jump
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (m_q.size() == 3 && m_pend != 0) found = 1'b1;
      else cycle(1'b0, 1'b0, 1'b0, 16'h0);
    end
    check("jmp_setup_reached", {31'b0, found}, 32'h1);
    cycle(1'b0, 1'b0, 1'b1, 16'h0040);
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0);
      if (i == 1) begin
        check("jmp_cnt_cleared", {29'b0, obs_cnt}, 32'h0);
        check("jmp_redirect_add", {15'h0, obs_cslt, obs_add}, {15'h0, 1'b1, 16'h0040});
      end
      if (obs_vld && k == 0) begin
        k = i;
        check("jmp_first_pc", {16'h0, obs_pc}, 32'h0040);
      end
    end
`ifdef FQ_BYPASS_EN
    check("jmp_vld_delay", k, 2);
`else
    check("jmp_vld_delay", k, 3);
`endif

    // busy window while draining
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0);

    // address wrap
    cycle(1'b0, 1'b1, 1'b1, 16'hFFFE);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0);
      if (obs_pop) got_pcs.push_back(obs_pc);
    end
    check("wrap_n", {31'b0, got_pcs.size() >= 4}, 32'h1);
    if (got_pcs.size() >= 4) begin
      check("wrap_pc0", {16'h0, got_pcs[0]}, 32'hFFFE);
      check("wrap_pc1", {16'h0, got_pcs[1]}, 32'hFFFF);
      check("wrap_pc2", {16'h0, got_pcs[2]}, 32'h0000);
      check("wrap_pc3", {16'h0, got_pcs[3]}, 32'h0001);
    end

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic        b, r, j;
      logic [15:0] a;
      b = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) < 6);
      j = ($urandom_range(0, 19) == 0);
      a = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom_range(0, 65535));
      cycle(b, r, j, a);
    end

    // reset with 2 queued and one in flight
    cycle(1'b0, 1'b0, 1'b1, 16'h0100);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (m_q.size() == 2 && m_pend != 0) found = 1'b1;
      else cycle(1'b0, 1'b0, 1'b0, 16'h0);
    end
    check("rst_setup_reached", {31'b0, found}, 32'h1);
    ps_fq_rdy = 1'b0;
    ps_fq_jmp = 1'b0;
    ps_pm_busy = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0);
      if (obs_cslt && !found) begin
        found = 1'b1;
        check("rst_first_add", {16'h0, obs_add}, 32'h0000);
      end
    end
    check("rst_refetch", {31'b0, found}, 32'h1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/ps_fetch_queue.md
Name: ps_fetch_queue

Overview:
- Instruction prefetch buffer between program memory and the program sequencer.
- Generates sequential PM read addresses and captures the PM read data.
- Buffers up to DEPTH instructions, each tagged with its fetch address.
- Presents the buffered instructions to the PS with a valid/ready handshake; a PS jump flushes the buffer and redirects fetching.

Parameters:
PMA_SIZE  16  program memory address width
PMD_SIZE  32  instruction word width
DEPTH  4  queue entries (power of 2, 2..16)
RESET_PC  16'h0000  first fetch address after reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
fq_pm_cslt  out  1  PM read select for this cycle
fq_pm_add  out  PMA_SIZE  PM read address (equals fetch PC register fpc)
pm_fq_op  in  PMD_SIZE  PM read data, valid the cycle after fq_pm_cslt
ps_pm_busy  in  1  PS owns the PM port this cycle; no fetch may issue
ps_fq_rdy  in  1  PS consumes the head entry this cycle
fq_ps_vld  out  1  head entry valid
fq_ps_instr  out  PMD_SIZE  head instruction (0 when empty)
fq_ps_pc  out  PMA_SIZE  address of head instruction (0 when empty)
ps_fq_jmp  in  1  redirect request
ps_fq_jadd  in  PMA_SIZE  redirect target
fq_ps_cnt  out  clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (reset=0, asynchronous):
  - fpc=RESET_PC, FSM=BOOT, count=0, in-flight flag=0.
  - fq_pm_cslt=0, fq_ps_vld=0, fq_ps_instr=0, fq_ps_pc=0, fq_ps_cnt=0.
  - Reset asserted mid-operation discards all entries and the in-flight read.
- FSM states BOOT, RUN, REDIR:
  - BOOT: first cycle after reset release. No issue. Next state RUN.
  - RUN: normal fetch. ps_fq_jmp moves the FSM to REDIR.
  - REDIR: the single cycle after a jump. Any pm_fq_op arriving this cycle is discarded (squashed in-flight). Issue is allowed. Next state RUN, or REDIR again if ps_fq_jmp=1.
- Issue rule (RUN or REDIR): fq_pm_cslt = !ps_pm_busy && !ps_fq_jmp && (count + inflight) < DEPTH.
  - The pop in the current cycle is not credited.
  - On issue, the in-flight flag and its tag (fpc) are set, and fpc <= fpc+1, wrapping modulo 2^PMA_SIZE.
- Response:
  - The cycle after an issue, pm_fq_op is written at the tail with its tag, unless squashed.
  - Latency: issue at cycle T, fq_ps_vld=1 at T+2 (FIFO initially empty).
- Pop: when ps_fq_rdy && fq_ps_vld, the head advances. ps_fq_rdy while !fq_ps_vld is ignored.
  - Simultaneous push and pop: count is unchanged.
  - The credit rule guarantees push never meets full.
- Jump at cycle T:
  - FIFO cleared and count=0 at end of T; fpc <= ps_fq_jadd; no issue at T.
  - A response due at T+1 is squashed.
  - The first fetch of ps_fq_jadd issues at T+1 (if not busy); vld returns at T+3.
  - A pop coinciding with the jump is legal and has no further effect.
  - The jump is accepted regardless of ps_pm_busy.
- ps_pm_busy only suppresses issue; the in-flight response still lands.
- fq_ps_cnt equals count as registered at the end of the previous cycle.
- Pointers are log2(DEPTH) bits and wrap naturally.

Optional Feature:
FQ_BYPASS_EN
- Defined:
  - When the FIFO is empty and a non-squashed response arrives, it is presented combinationally that cycle: fq_ps_vld=1, fq_ps_instr=pm_fq_op, fq_ps_pc=tag.
  - If ps_fq_rdy=1 that cycle, it is consumed and not written into the FIFO.
  - Issue-to-valid latency becomes 1 cycle; post-jump latency becomes 2.
- Undefined: no bypass; latencies as in Behaviour.

Test Plan:
- Reset release, RESET_PC=0, PM holds word 32'hA000_0000+addr, ps_fq_rdy=0:
  - fetches issue at addr 0,1,2,3, then fq_pm_cslt stays 0.
  - fq_ps_cnt reaches 4.
  - head instr=32'hA000_0000, pc=0.
- Streaming with ps_fq_rdy=1 continuously:
  - one instruction consumed per cycle after startup.
  - pc sequence 0,1,2,... without gaps.
  - count stable at ≤2 (no bypass).
- ps_fq_jmp=1, ps_fq_jadd=16'h0040, with the FIFO holding 3 entries and one read in flight:
  - next cycle fq_ps_cnt=0.
  - the in-flight word never appears.
  - the next fq_pm_add=16'h0040.
  - first valid pc=16'h0040, 3 cycles after the jump.
- ps_pm_busy=1 for 3 cycles while the queue is draining:
  - fq_pm_cslt=0 for those cycles.
  - already in-flight data is still queued.
  - fetch resumes at the next sequential address.
- Wrap: jump to 16'hFFFE, rdy=1:
  - delivered pcs are FFFE, FFFF, 0000, 0001.
- Reset asserted with 2 entries queued and a read in flight:
  - all outputs go to 0 immediately.
  - after release, the first fetch address is RESET_PC.
- With FQ_BYPASS_EN defined:
  - a response arriving to an empty queue with rdy=1 shows vld=1 in the arrival cycle.
  - fq_ps_cnt stays 0.
